// File: rtl/riscv_aes_loader_if.sv
// Core-side stream, register-file write port and AES control/status for the loader.
// The loader drives the slave modport, and the core or bench drives the master modport.
interface riscv_aes_loader_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  swap_i;
  logic                  abort_i;
  logic                  aes_done_i;
  logic                  err_clr_i;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic                  wen_o;
  logic                  aes_start_o;
  logic                  busy_o;
  logic                  err_o;
  logic [15:0]           blocks_o;

  modport master (
    output in_valid_i, in_data_i, swap_i, abort_i, aes_done_i, err_clr_i,
    input  in_ready_o, waddr_o, wdata_o, wen_o, aes_start_o, busy_o, err_o, blocks_o
  );

  modport slave (
    input  in_valid_i, in_data_i, swap_i, abort_i, aes_done_i, err_clr_i,
    output in_ready_o, waddr_o, wdata_o, wen_o, aes_start_o, busy_o, err_o, blocks_o
  );
endinterface

// File: rtl/riscv_aes_loader.sv
// Feeds four words into the AES register file, then starts the engine and waits for done.
// A watchdog bounds the wait and raises a sticky error when it expires.
module riscv_aes_loader #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input logic              clk,
  input logic              rst,
  riscv_aes_loader_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_START = 2'd2;
  localparam logic [1:0] ST_BUSY  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = '1;
  localparam logic [15:0]           TMO_LIMIT = 16'(TIMEOUT);

  logic [1:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] count_reg, count_next;
  logic [15:0]           tmo_reg, tmo_next;
  logic [15:0]           blocks_reg;
  logic                  err_reg;
  logic                  start_reg;
  logic                  wen_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] swapped;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ready;
  logic                  accept;
  logic                  set_err;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_swap
      assign swapped[8*gi +: 8] = bus.in_data_i[DATA_WIDTH-8-8*gi +: 8];
    end
  endgenerate

  assign wr_data = bus.swap_i ? swapped : bus.in_data_i;
  assign ready   = (state_reg == ST_IDLE) || (state_reg == ST_LOAD);
  // Abort only cancels a partial block; in IDLE there is nothing to cancel.
  assign accept  = bus.in_valid_i && ready && (!bus.abort_i || (state_reg == ST_IDLE));

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    tmo_next   = tmo_reg;
    set_err    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          count_next = count_reg + 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.abort_i) begin
          count_next = '0;
          state_next = ST_IDLE;
        end else if (accept) begin
          if (count_reg == LAST_WORD) begin
            count_next = '0;
            state_next = ST_START;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
      ST_START: begin
        tmo_next   = '0;
        state_next = ST_BUSY;
      end
      ST_BUSY: begin
        // Done is checked first so it wins over a coincident timeout.
        if (bus.aes_done_i) begin
          state_next = ST_IDLE;
        end else if (tmo_reg == TMO_LIMIT) begin
          set_err    = 1'b1;
          state_next = ST_IDLE;
        end else begin
          tmo_next = tmo_reg + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      tmo_reg    <= '0;
      blocks_reg <= '0;
      err_reg    <= 1'b0;
      start_reg  <= 1'b0;
      wen_reg    <= 1'b0;
      waddr_reg  <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      tmo_reg   <= tmo_next;
      wen_reg   <= accept;
      if (accept) begin
        waddr_reg <= count_reg;
        wdata_reg <= wr_data;
      end
      // The start pulse lands in the first BUSY cycle, after word 3 is committed.
      start_reg <= (state_reg == ST_START);
      if (state_reg == ST_START) begin
        blocks_reg <= blocks_reg + 16'd1;
      end
      if (set_err) begin
        err_reg <= 1'b1;
      end else if (bus.err_clr_i) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o  = ready;
  assign bus.waddr_o     = waddr_reg;
  assign bus.wdata_o     = wdata_reg;
  assign bus.wen_o       = wen_reg;
  assign bus.aes_start_o = start_reg;
  assign bus.busy_o      = (state_reg == ST_START) || (state_reg == ST_BUSY);
  assign bus.err_o       = err_reg;
  assign bus.blocks_o    = blocks_reg;
endmodule

// File: tb/tb_riscv_aes_loader.sv
// Directed bench for riscv_aes_loader with a short watchdog (TIMEOUT = 4).
// It prints one line per written word and one per block event.
module tb_riscv_aes_loader;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  riscv_aes_loader_if #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) bus ();

  riscv_aes_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(bus.in_ready_o), 32'd1);
    check({tag, "_wen"}, 32'(bus.wen_o), 32'd0);
    check({tag, "_waddr"}, 32'(bus.waddr_o), 32'd0);
    check({tag, "_wdata"}, bus.wdata_o, 32'd0);
    check({tag, "_start"}, 32'(bus.aes_start_o), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    check({tag, "_err"}, 32'(bus.err_o), 32'd0);
    check({tag, "_blocks"}, 32'(bus.blocks_o), 32'd0);
  endtask

  // Presents one word for one cycle and checks the registered write that follows.
  task automatic send_word(input logic [31:0] d, input logic sw, input logic [1:0] exp_addr,
                           input logic [31:0] exp_data);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = d;
    bus.swap_i     = sw;
    tick();
    $display("write in=%h swap=%0d -> wen=%0d addr=%0d data=%h", d, sw, bus.wen_o, bus.waddr_o,
             bus.wdata_o);
    check("wr_wen", 32'(bus.wen_o), 32'd1);
    check("wr_addr", 32'(bus.waddr_o), 32'(exp_addr));
    check("wr_data", bus.wdata_o, exp_data);
    bus.in_valid_i = 1'b0;
    bus.swap_i     = 1'b0;
  endtask

  task automatic load_block(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      send_word(base + 32'(i), 1'b0, 2'(i), base + 32'(i));
    end
    check("start_state_busy", 32'(bus.busy_o), 32'd1);
    check("start_state_ready", 32'(bus.in_ready_o), 32'd0);
    check("start_state_pulse", 32'(bus.aes_start_o), 32'd0);
  endtask

  task automatic start_cycle(input logic [15:0] exp_blocks);
    tick();
    $display("start pulse=%0d blocks=%h", bus.aes_start_o, bus.blocks_o);
    check("start_pulse", 32'(bus.aes_start_o), 32'd1);
    check("start_blocks", 32'(bus.blocks_o), 32'(exp_blocks));
    check("start_wen", 32'(bus.wen_o), 32'd0);
  endtask

  task automatic finish_done();
    bus.aes_done_i = 1'b1;
    tick();
    bus.aes_done_i = 1'b0;
    $display("done -> ready=%0d busy=%0d err=%0d", bus.in_ready_o, bus.busy_o, bus.err_o);
    check("done_ready", 32'(bus.in_ready_o), 32'd1);
    check("done_busy", 32'(bus.busy_o), 32'd0);
    check("done_pulse", 32'(bus.aes_start_o), 32'd0);
    check("done_err", 32'(bus.err_o), 32'd0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = '0;
    bus.swap_i     = 1'b0;
    bus.abort_i    = 1'b0;
    bus.aes_done_i = 1'b0;
    bus.err_clr_i  = 1'b0;
    tick();
    tick();
    check_reset("rst0");
    rst = 1'b0;

    // Back-to-back block: writes in cycles 1..4, start in cycle 5.
    send_word(32'h11111111, 1'b0, 2'd0, 32'h11111111);
    send_word(32'h22222222, 1'b0, 2'd1, 32'h22222222);
    send_word(32'h33333333, 1'b0, 2'd2, 32'h33333333);
    send_word(32'h44444444, 1'b0, 2'd3, 32'h44444444);
    check("b1_ready_low", 32'(bus.in_ready_o), 32'd0);
    start_cycle(16'h0001);
    finish_done();

    // Byte reversal.
    send_word(32'h01020304, 1'b1, 2'd0, 32'h04030201);
    send_word(32'hA0B0C0D0, 1'b1, 2'd1, 32'hD0C0B0A0);
    send_word(32'h55667788, 1'b0, 2'd2, 32'h55667788);
    send_word(32'hDEADBEEF, 1'b1, 2'd3, 32'hEFBEADDE);
    start_cycle(16'h0002);
    finish_done();

    // Abort with a valid third word, then abort held while IDLE accepts.
    send_word(32'hAAAA0000, 1'b0, 2'd0, 32'hAAAA0000);
    send_word(32'hAAAA0001, 1'b0, 2'd1, 32'hAAAA0001);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 32'h99999999;
    bus.abort_i    = 1'b1;
    tick();
    $display("abort -> wen=%0d ready=%0d busy=%0d", bus.wen_o, bus.in_ready_o, bus.busy_o);
    check("abort_wen", 32'(bus.wen_o), 32'd0);
    check("abort_ready", 32'(bus.in_ready_o), 32'd1);
    check("abort_busy", 32'(bus.busy_o), 32'd0);
    send_word(32'hBBBB0000, 1'b0, 2'd0, 32'hBBBB0000);
    bus.abort_i = 1'b0;
    send_word(32'hBBBB0001, 1'b0, 2'd1, 32'hBBBB0001);
    send_word(32'hBBBB0002, 1'b0, 2'd2, 32'hBBBB0002);
    send_word(32'hBBBB0003, 1'b0, 2'd3, 32'hBBBB0003);
    start_cycle(16'h0003);
    finish_done();

    // Timeout: BUSY lasts TIMEOUT+1 cycles, then err and IDLE.
    load_block(32'hC0000000);
    start_cycle(16'h0004);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("tmo_wait_busy", 32'(bus.busy_o), 32'd1);
      check("tmo_wait_err", 32'(bus.err_o), 32'd0);
    end
    tick();
    $display("timeout -> err=%0d ready=%0d busy=%0d", bus.err_o, bus.in_ready_o, bus.busy_o);
    check("tmo_err", 32'(bus.err_o), 32'd1);
    check("tmo_ready", 32'(bus.in_ready_o), 32'd1);
    check("tmo_busy", 32'(bus.busy_o), 32'd0);
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    check("err_clr", 32'(bus.err_o), 32'd0);

    // Done in the same cycle the timeout count hits its limit.
    load_block(32'hD0000000);
    start_cycle(16'h0005);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("race_wait_busy", 32'(bus.busy_o), 32'd1);
    end
    finish_done();
    tick();
    check("race_err_hold", 32'(bus.err_o), 32'd0);

    // Reset during LOAD after three words.
    send_word(32'hE0000000, 1'b0, 2'd0, 32'hE0000000);
    send_word(32'hE0000001, 1'b0, 2'd1, 32'hE0000001);
    send_word(32'hE0000002, 1'b0, 2'd2, 32'hE0000002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset in LOAD");
    check_reset("rst_load");
    tick();
    check("rst_load_nostart", 32'(bus.aes_start_o), 32'd0);

    // Reset in START, then reset in BUSY.
    load_block(32'hF0000000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset in START");
    check_reset("rst_start");
    tick();
    check("rst_start_nostart", 32'(bus.aes_start_o), 32'd0);
    load_block(32'hF1000000);
    start_cycle(16'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset in BUSY");
    check_reset("rst_busy");

    // Block counter wrap from 0xFFFF.
    tick();
    force dut.blocks_reg = 16'hFFFF;
    tick();
    release dut.blocks_reg;
    tick();
    check("wrap_preload", 32'(bus.blocks_o), 32'h0000FFFF);
    load_block(32'h12340000);
    start_cycle(16'h0000);
    finish_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_aes_loader.md
# riscv_aes_loader

Upstream feeder for the RISC-V AES 4x32 register file. It accepts 32-bit words from the core over a valid/ready stream and writes them into register-file words 0..3 in order through the file's write port. After the fourth word has been written, it pulses the AES start strobe, then waits for the engine's done indication, with a watchdog timeout. It also reports busy/error status and counts started blocks.

## Interface
Parameters:
- ADDR_WIDTH, 2: register-file address width (4 words).
- DATA_WIDTH, 32: word width.
- TIMEOUT, 64: maximum BUSY cycles to wait for `aes_done_i`. Legal range 1..65535.

Ports:
- `clk`  in  1  — the single clock; all logic is on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid_i`  in  1  — input word valid.
- `in_ready_o`  out  1  — loader can accept a word.
- `in_data_i`  in  DATA_WIDTH  — input word.
- `swap_i`  in  1  — byte-reverse this word; sampled with each accepted word.
- `abort_i`  in  1  — discard a partial block. Acts only in LOAD.
- `aes_done_i`  in  1  — engine-finished pulse. Acts only in BUSY.
- `err_clr_i`  in  1  — clears `err_o`.
- `waddr_o`  out  ADDR_WIDTH  — register-file write address.
- `wdata_o`  out  DATA_WIDTH  — register-file write data.
- `wen_o`  out  1  — register-file write enable.
- `aes_start_o`  out  1  — one-cycle start pulse to the AES engine.
- `busy_o`  out  1  — high when the state is START or BUSY.
- `err_o`  out  1  — sticky timeout flag.
- `blocks_o`  out  16  — count of started blocks; wraps modulo 2^16.

## Operation
- States and their meaning:
  - IDLE: word count 0, waiting for the first word.
  - LOAD: 1..3 words written, waiting for the rest.
  - START: all four writes issued.
  - BUSY: waiting for `aes_done_i`.
- `in_ready_o` = 1 in IDLE and LOAD; 0 in START and BUSY. It does not depend on `in_valid_i`.
- A word is accepted when `in_valid_i & in_ready_o & ~abort_i`. In IDLE, `abort_i` does not block acceptance.
- Each accepted word is written:
  - `waddr_o` = word count (0..3); the count then increments.
  - `wdata_o` = `in_data_i`, byte-reversed when `swap_i` = 1 ({b0,b1,b2,b3}).
- State transitions:
  - IDLE → LOAD on the first accepted word.
  - LOAD → START when the word at count 3 is accepted.
  - START → BUSY unconditionally after one cycle.
  - BUSY → IDLE on `aes_done_i`, or on timeout.
- Abort: `abort_i` in LOAD returns to IDLE and resets the count to 0. Words already written stay in the register file; no start is issued. A word presented in the same cycle as `abort_i` is neither accepted nor written.
- Timeout counter:
  - Cleared on entry to BUSY; increments each BUSY cycle in which `aes_done_i` = 0.
  - When the count reaches TIMEOUT, `err_o` is set and the state returns to IDLE.
  - If `aes_done_i` and the timeout occur in the same cycle, done wins and `err_o` is not set.
- `err_o` priority: set wins over `err_clr_i` in the same cycle. Otherwise `err_clr_i` clears it. `err_o` does not block new loads.
- `blocks_o` increments in the cycle `aes_start_o` is asserted; 0xFFFF wraps to 0x0000.
- `aes_done_i` outside BUSY and `abort_i` outside LOAD are ignored.

## Timing
- Reset values: state IDLE, count 0, `in_ready_o` = 1, `wen_o` = 0, `waddr_o` = 0, `wdata_o` = 0, `aes_start_o` = 0, `busy_o` = 0, `err_o` = 0, `blocks_o` = 0.
- `rst` has priority over all other inputs. Reset mid-block or in BUSY returns everything to the reset values the next cycle; no start pulse is emitted.
- `wen_o`, `waddr_o`, `wdata_o` are registered: a word accepted in cycle t is written in cycle t+1.
- Throughput: one word per cycle. Four back-to-back words need 4 cycles.
- Fourth word accepted in cycle t:
  - write of word 3 and state START in t+1;
  - `aes_start_o` = 1 in t+2 only, first BUSY cycle, after word 3 is committed;
  - `in_ready_o` = 0 from t+1 until the cycle after BUSY exits.
- `aes_done_i` in cycle d → IDLE with `in_ready_o` = 1 in d+1.
- No `aes_done_i` → `err_o` = 1 and state IDLE exactly TIMEOUT+1 cycles after BUSY entry.

## Test plan
- After reset, stream words 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back from cycle 0. Required: writes to addresses 0..3 in cycles 1..4, one `aes_start_o` pulse in cycle 5, `blocks_o` = 1.
- Stream with `swap_i` = 1 on 0x01020304. Required: `wdata_o` = 0x04030201.
- Accept 2 words, then assert `abort_i` together with a valid third word. Required: no write for that word, state IDLE; the next four words write addresses 0..3 and trigger a start.
- TIMEOUT = 4, no `aes_done_i`. Required: `err_o` = 1 and `in_ready_o` = 1 five cycles after BUSY entry. `err_clr_i` then clears `err_o`.
- `aes_done_i` in the same cycle the timeout count hits TIMEOUT. Required: `err_o` stays 0, return to IDLE.
- Assert `rst` during LOAD after 3 words, and separately during BUSY. Required: all reset values next cycle, no `aes_start_o`. Preload `blocks_o` = 0xFFFF and complete one block. Required: `blocks_o` = 0.
